// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame states, set-2 prefix bytes and device-reply classification.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2State;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  function automatic logic isReply(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: two-flop synchroniser plus a glitch filter that only moves after FILTER equal samples.
module ps2_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER - 1);
  logic [1:0] sync;
  logic [CW-1:0] count;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      count <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      if (sync[1] == level) count <= '0;
      else if (count == LAST) begin
        level <= sync[1];
        count <= '0;
        fall  <= level;
      end else count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/ps2k_rx.sv
// ps2k_rx: PS/2 keyboard receiver turning set-2 frames into single make/break key events.
module ps2k_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 32000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ps2,
  output logic       strb,
  output logic       make,
  output logic       ext,
  output logic [7:0] code,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);
  ps2State state;
  logic fall, dataLevel, unusedClkLevel, unusedDataFall;
  logic [2:0] bitCount, skip;
  logic [7:0] shift;
  logic parBit, byteValid, extFlag, brkFlag;
  logic [TW-1:0] tmo;
  ps2_filter #(.FILTER(FILTER)) clkFilter (
    .clock(clock), .reset(reset), .line(ps2[0]), .level(unusedClkLevel), .fall(fall)
  );
  ps2_filter #(.FILTER(FILTER)) dataFilter (
    .clock(clock), .reset(reset), .line(ps2[1]), .level(dataLevel), .fall(unusedDataFall)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bitCount  <= '0;
      skip      <= '0;
      shift     <= '0;
      parBit    <= 1'b0;
      byteValid <= 1'b0;
      extFlag   <= 1'b0;
      brkFlag   <= 1'b0;
      tmo       <= '0;
      strb      <= 1'b0;
      make      <= 1'b0;
      ext       <= 1'b0;
      code      <= 8'h00;
      err       <= 1'b0;
    end else begin
      strb      <= 1'b0;
      err       <= 1'b0;
      byteValid <= 1'b0;
      tmo       <= (state == IDLE || fall) ? '0 : tmo + 1'b1;
      if (state != IDLE && tmo == TLIMIT) state <= IDLE;
      else if (fall) begin
        case (state)
          IDLE: if (!dataLevel) begin
            state    <= DATA;
            bitCount <= '0;
          end
          DATA: begin
            shift    <= {dataLevel, shift[7:1]};
            bitCount <= bitCount + 1'b1;
            if (bitCount == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parBit <= dataLevel;
            state  <= STOP;
          end
          default: begin
            state <= IDLE;
            if (dataLevel && ^{shift, parBit}) byteValid <= 1'b1;
            else begin
              err     <= 1'b1;
              extFlag <= 1'b0;
              brkFlag <= 1'b0;
            end
          end
        endcase
      end
      // the received byte stays in shift until the next frame's first data bit
      if (byteValid) begin
        if (skip != 3'd0) skip <= skip - 1'b1;
        else if (shift == PS2_PAUSE) begin
          skip    <= 3'd7;
          extFlag <= 1'b0;
          brkFlag <= 1'b0;
        end else if (shift == PS2_EXT) extFlag <= 1'b1;
        else if (shift == PS2_BRK) brkFlag <= 1'b1;
        else if (!isReply(shift)) begin
          strb    <= 1'b1;
          code    <= shift;
          make    <= !brkFlag;
          ext     <= extFlag;
          extFlag <= 1'b0;
          brkFlag <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2k_rx.sv
// tb_ps2k_rx: directed frames into ps2k_rx, checking key events, errors, timeout and reset.
module tb_ps2k_rx;
  localparam int HALF = 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] ps2 = 2'b11;
  logic strb, make, ext, err;
  logic [7:0] code;
  int compared = 0, mismatched = 0;
  int strbSeen = 0, errSeen = 0, overlap = 0;

  ps2k_rx dut (
    .clock(clock), .reset(reset), .ps2(ps2),
    .strb(strb), .make(make), .ext(ext), .code(code), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (strb) strbSeen++;
    if (err) errSeen++;
    if (strb && err) overlap++;
  end

  task automatic sendBit(input logic b);
    ps2[1] = b;
    repeat (HALF / 2) @(posedge clock);
    ps2[0] = 1'b0;
    repeat (HALF) @(posedge clock);
    ps2[0] = 1'b1;
    repeat (HALF / 2) @(posedge clock);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic flip);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit((~^b) ^ flip);
    sendBit(1'b1);
    repeat (20) @(posedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    compared++;
    if ({strb, make, ext, code, err} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want %h", {strb, make, ext, code, err}, 12'h000);
    end
    reset = 1'b0;
    repeat (20) @(posedge clock);
    compared++;
    if (strbSeen + errSeen !== 0) begin
      mismatched++;
      $display("FAIL reset_quiet: got %0d pulses want 0", strbSeen + errSeen);
    end
  endtask

  task automatic test_single;
    int s0, e0;
    s0 = strbSeen; e0 = errSeen;
    sendByte(8'h1C, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1) begin mismatched++; $display("FAIL single_strb: got %0d want 1", strbSeen - s0); end
    compared++;
    if ({make, ext, code} !== {1'b1, 1'b0, 8'h1C}) begin
      mismatched++; $display("FAIL single_event: got make=%b ext=%b code=%h want 1 0 1c", make, ext, code);
    end
    compared++;
    if (errSeen - e0 !== 0) begin mismatched++; $display("FAIL single_err: got %0d want 0", errSeen - e0); end
  endtask

  task automatic test_break;
    int s0;
    s0 = strbSeen;
    sendByte(8'hF0, 1'b0);
    sendByte(8'h1C, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1) begin mismatched++; $display("FAIL break_strb: got %0d want 1", strbSeen - s0); end
    compared++;
    if ({make, ext, code} !== {1'b0, 1'b0, 8'h1C}) begin
      mismatched++; $display("FAIL break_event: got make=%b ext=%b code=%h want 0 0 1c", make, ext, code);
    end
    s0 = strbSeen;
    sendByte(8'hE0, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h75, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1) begin mismatched++; $display("FAIL extbreak_strb: got %0d want 1", strbSeen - s0); end
    compared++;
    if ({make, ext, code} !== {1'b0, 1'b1, 8'h75}) begin
      mismatched++; $display("FAIL extbreak_event: got make=%b ext=%b code=%h want 0 1 75", make, ext, code);
    end
  endtask

  task automatic test_parity;
    int s0, e0;
    sendByte(8'hF0, 1'b0);
    s0 = strbSeen; e0 = errSeen;
    sendByte(8'h1C, 1'b1);
    @(negedge clock);
    compared++;
    if (errSeen - e0 !== 1) begin mismatched++; $display("FAIL parity_err: got %0d want 1", errSeen - e0); end
    compared++;
    if (strbSeen - s0 !== 0) begin mismatched++; $display("FAIL parity_strb: got %0d want 0", strbSeen - s0); end
    sendByte(8'hE0, 1'b0);
    sendByte(8'h75, 1'b0);
    @(negedge clock);
    compared++;
    if ({make, ext, code} !== {1'b1, 1'b1, 8'h75}) begin
      mismatched++; $display("FAIL parity_recover: got make=%b ext=%b code=%h want 1 1 75", make, ext, code);
    end
  endtask

  task automatic test_timeout;
    int s0, e0;
    s0 = strbSeen; e0 = errSeen;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    repeat (32001) @(posedge clock);
    sendByte(8'h01, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1) begin mismatched++; $display("FAIL timeout_strb: got %0d want 1", strbSeen - s0); end
    compared++;
    if (code !== 8'h01) begin mismatched++; $display("FAIL timeout_code: got %h want 01", code); end
    compared++;
    if (errSeen - e0 !== 0) begin mismatched++; $display("FAIL timeout_err: got %0d want 0", errSeen - e0); end
  endtask

  task automatic test_pause;
    int s0;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    s0 = strbSeen;
    for (int i = 0; i < 8; i++) sendByte(seq[i], 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 0) begin mismatched++; $display("FAIL pause_strb: got %0d want 0", strbSeen - s0); end
    sendByte(8'hAA, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 0) begin mismatched++; $display("FAIL reply_strb: got %0d want 0", strbSeen - s0); end
    sendByte(8'h05, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1) begin mismatched++; $display("FAIL after_pause_strb: got %0d want 1", strbSeen - s0); end
    compared++;
    if ({make, ext, code} !== {1'b1, 1'b0, 8'h05}) begin
      mismatched++; $display("FAIL after_pause_event: got make=%b ext=%b code=%h want 1 0 05", make, ext, code);
    end
  endtask

  task automatic test_glitch_reset;
    int s0, e0;
    s0 = strbSeen;
    ps2[1] = 1'b0;
    ps2[0] = 1'b0;
    repeat (3) @(posedge clock);
    ps2[0] = 1'b1;
    repeat (10) @(posedge clock);
    ps2[1] = 1'b1;
    repeat (50) @(posedge clock);
    sendByte(8'h1C, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1 || code !== 8'h1C) begin
      mismatched++; $display("FAIL glitch_event: got %0d strb code=%h want 1 strb code=1c", strbSeen - s0, code);
    end
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    compared++;
    if (code !== 8'h00) begin mismatched++; $display("FAIL midreset_code: got %h want 00", code); end
    reset = 1'b0;
    repeat (20) @(posedge clock);
    s0 = strbSeen; e0 = errSeen;
    sendByte(8'h23, 1'b0);
    @(negedge clock);
    compared++;
    if (strbSeen - s0 !== 1 || code !== 8'h23) begin
      mismatched++; $display("FAIL midreset_event: got %0d strb code=%h want 1 strb code=23", strbSeen - s0, code);
    end
    compared++;
    if (errSeen - e0 !== 0) begin mismatched++; $display("FAIL midreset_err: got %0d want 0", errSeen - e0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_break;
    test_parity;
    test_timeout;
    test_pause;
    test_glitch_reset;
    compared++;
    if (overlap !== 0) begin mismatched++; $display("FAIL strb_err_overlap: got %0d want 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
